// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int unsigned MAX_RD_LAT = 3;
  localparam int unsigned CNT_W      = $clog2(MAX_RD_LAT + 1);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker; a tie goes to whoever did not win last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] gnt,
  output logic       winner
);

  always_comb begin
    winner = OWN_CPU;
    gnt    = 2'b00;
    if (req == 2'b11) begin
      winner = ~last_owner;
    end else if (req[1]) begin
      winner = OWN_LDR;
    end
    if (|req) begin
      gnt = winner ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and loader accesses onto a single-port memory, one
// outstanding transaction at a time, with a programmable read latency.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_adr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic          ldr_rvalid,
  output logic [DW-1:0] ldr_rdata,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]      adr_q, adr_d;
  logic               last_owner_q, last_owner_d;
  logic               owner_q, owner_d;

  logic [1:0]         arb_gnt;
  logic               arb_winner;

  rr_arb2 u_rr_arb2 (
    .req        ({ldr_req, cpu_req}),
    .last_owner (last_owner_q),
    .gnt        (arb_gnt),
    .winner     (arb_winner)
  );

  // Next-state and steering; grants and the issue address are same-cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    adr_d        = adr_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    cpu_gnt      = 1'b0;
    ldr_gnt      = 1'b0;
    cpu_rvalid   = 1'b0;
    ldr_rvalid   = 1'b0;
    cpu_rdata    = '0;
    ldr_rdata    = '0;
    mem_adr      = adr_q;
    mem_wdata    = '0;
    mem_we       = 1'b0;
    busy         = 1'b0;
    owner        = owner_q;

    case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          cpu_gnt      = arb_gnt[0];
          ldr_gnt      = arb_gnt[1];
          mem_adr      = arb_winner ? ldr_adr   : cpu_adr;
          mem_wdata    = arb_winner ? ldr_wdata : cpu_wdata;
          mem_we       = arb_winner ? ldr_we    : cpu_we;
          adr_d        = mem_adr;
          last_owner_d = arb_winner;
          owner_d      = arb_winner;
          if (!mem_we) begin
            state_d = RD_WAIT;
            cnt_d   = CNT_W'(RD_LAT);
          end
        end
      end
      RD_WAIT: begin
        busy  = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (owner_q == OWN_LDR) begin
            ldr_rvalid = 1'b1;
            ldr_rdata  = mem_rdata;
          end else begin
            cpu_rvalid = 1'b1;
            cpu_rdata  = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset silences every output, including any read completing this cycle.
    if (reset) begin
      cpu_gnt    = 1'b0;
      ldr_gnt    = 1'b0;
      cpu_rvalid = 1'b0;
      ldr_rvalid = 1'b0;
      cpu_rdata  = '0;
      ldr_rdata  = '0;
      mem_adr    = '0;
      mem_wdata  = '0;
      mem_we     = 1'b0;
      busy       = 1'b0;
      owner      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      adr_q        <= '0;
      last_owner_q <= OWN_LDR;
      owner_q      <= OWN_CPU;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      adr_q        <= adr_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
    end
  end

  rd_lat_legal: assert property (@(posedge clk) (RD_LAT >= 1) && (RD_LAT <= MAX_RD_LAT))
    else $error("mem_arbiter: RD_LAT=%0d outside 1..%0d", RD_LAT, MAX_RD_LAT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with RD_LAT=2 and a simple memory model.
module tb_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, ldr_req, ldr_we;
  logic [AW-1:0] cpu_adr, ldr_adr, mem_adr;
  logic [DW-1:0] cpu_wdata, ldr_wdata, mem_wdata, mem_rdata;
  logic          cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid, mem_we, busy, owner;
  logic [DW-1:0] cpu_rdata, ldr_rdata;
  logic [6:0]    flags;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:4095];

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_adr    (cpu_adr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_adr    (ldr_adr),
    .ldr_wdata  (ldr_wdata),
    .ldr_gnt    (ldr_gnt),
    .ldr_rvalid (ldr_rvalid),
    .ldr_rdata  (ldr_rdata),
    .mem_adr    (mem_adr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .owner      (owner)
  );

  always #5 clk = ~clk;

  // Memory model: held address read combinationally, writes on the edge.
  assign mem_rdata = mem[mem_adr[11:0]];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
      mem[16] <= 16'h1234;
    end else if (mem_we) begin
      mem[mem_adr[11:0]] <= mem_wdata;
    end
  end

  // {cpu_gnt, ldr_gnt, mem_we, busy, cpu_rvalid, ldr_rvalid, owner}
  assign flags = {cpu_gnt, ldr_gnt, mem_we, busy, cpu_rvalid, ldr_rvalid, owner};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = r; cpu_we = w; cpu_adr = a; cpu_wdata = d;
  endtask

  task automatic set_ldr(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ldr_req = r; ldr_we = w; ldr_adr = a; ldr_wdata = d;
  endtask

  task automatic test_reset();
    set_cpu(1'b1, 1'b1, 16'h0033, 16'hFFFF);
    set_ldr(1'b1, 1'b1, 16'h0044, 16'hFFFF);
    @(negedge clk);
    checks++;
    if (flags !== 7'b0000000) begin errors++; $display("FAIL reset_flags: got %b exp 0000000", flags); end
    checks++;
    if ({mem_adr, mem_wdata, cpu_rdata, ldr_rdata} !== '0) begin
      errors++; $display("FAIL reset_buses: adr %h wdata %h crd %h lrd %h exp all 0", mem_adr, mem_wdata, cpu_rdata, ldr_rdata);
    end
    step();
    reset = 1'b0;
    set_cpu(1'b0, 1'b0, '0, '0);
    set_ldr(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (flags !== 7'b0000000 || mem_adr !== 16'h0000) begin
      errors++; $display("FAIL idle_after_reset: flags %b adr %h exp 0000000 0000", flags, mem_adr);
    end
    step();
  endtask

  task automatic test_single_read();
    set_cpu(1'b1, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    checks++;
    if (flags !== 7'b1000000 || mem_adr !== 16'h0010) begin
      errors++; $display("FAIL rd_issue: flags %b adr %h exp 1000000 0010", flags, mem_adr);
    end
    step();
    set_cpu(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (flags !== 7'b0001000 || mem_adr !== 16'h0010 || cpu_rdata !== 16'h0) begin
      errors++; $display("FAIL rd_t1: flags %b adr %h rd %h exp 0001000 0010 0000", flags, mem_adr, cpu_rdata);
    end
    step();
    @(negedge clk);
    checks++;
    if (flags !== 7'b0001100 || cpu_rdata !== 16'h1234 || ldr_rdata !== 16'h0) begin
      errors++; $display("FAIL rd_t2: flags %b crd %h lrd %h exp 0001100 1234 0000", flags, cpu_rdata, ldr_rdata);
    end
    step();
    @(negedge clk);
    checks++;
    if (flags !== 7'b0000000 || cpu_rdata !== 16'h0) begin
      errors++; $display("FAIL rd_t3: flags %b crd %h exp 0000000 0000", flags, cpu_rdata);
    end
    step();
  endtask

  task automatic test_contention();
    logic          exp_cpu;
    logic [6:0]    exp_flags;
    logic [AW-1:0] exp_adr;
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_cpu(1'b1, 1'b1, 16'h0020, 16'hAAAA);
    set_ldr(1'b1, 1'b1, 16'h0030, 16'h5555);
    for (int i = 0; i < 4; i++) begin
      exp_cpu   = (i % 2 == 0);
      exp_flags = {exp_cpu, ~exp_cpu, 1'b1, 3'b000, (i == 2)};
      exp_adr   = exp_cpu ? 16'h0020 : 16'h0030;
      @(negedge clk);
      checks++;
      if (flags !== exp_flags || mem_adr !== exp_adr) begin
        errors++; $display("FAIL contention_%0d: flags %b adr %h exp %b %h", i, flags, mem_adr, exp_flags, exp_adr);
      end
      step();
    end
    set_cpu(1'b0, 1'b0, '0, '0);
    set_ldr(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (mem[12'h020] !== 16'hAAAA || mem[12'h030] !== 16'h5555) begin
      errors++; $display("FAIL contention_mem: [20]=%h [30]=%h exp AAAA 5555", mem[12'h020], mem[12'h030]);
    end
    step();
  endtask

  task automatic test_write_read();
    set_ldr(1'b1, 1'b1, 16'h0100, 16'hBEEF);
    @(negedge clk);
    checks++;
    if (flags !== 7'b0110001 || mem_adr !== 16'h0100 || mem_wdata !== 16'hBEEF) begin
      errors++; $display("FAIL ldr_write: flags %b adr %h wd %h exp 0110001 0100 BEEF", flags, mem_adr, mem_wdata);
    end
    step();
    set_ldr(1'b0, 1'b0, '0, '0);
    set_cpu(1'b1, 1'b0, 16'h0100, 16'h0000);
    @(negedge clk);
    checks++;
    if (flags !== 7'b1000001 || mem_adr !== 16'h0100) begin
      errors++; $display("FAIL wr_rd_issue: flags %b adr %h exp 1000001 0100", flags, mem_adr);
    end
    step();
    set_cpu(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (flags !== 7'b0001000) begin errors++; $display("FAIL wr_rd_t1: flags %b exp 0001000", flags); end
    step();
    @(negedge clk);
    checks++;
    if (flags !== 7'b0001100 || cpu_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL wr_rd_t2: flags %b crd %h exp 0001100 BEEF", flags, cpu_rdata);
    end
    step();
  endtask

  task automatic test_req_during_read();
    set_cpu(1'b1, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    checks++;
    if (flags !== 7'b1000000) begin errors++; $display("FAIL rdr_issue: flags %b exp 1000000", flags); end
    step();
    set_cpu(1'b0, 1'b0, '0, '0);
    set_ldr(1'b1, 1'b1, 16'h0040, 16'h7777);
    @(negedge clk);
    checks++;
    if (flags !== 7'b0001000 || mem_adr !== 16'h0010) begin
      errors++; $display("FAIL rdr_t1: flags %b adr %h exp 0001000 0010", flags, mem_adr);
    end
    step();
    @(negedge clk);
    checks++;
    if (flags !== 7'b0001100 || cpu_rdata !== 16'h1234) begin
      errors++; $display("FAIL rdr_t2: flags %b crd %h exp 0001100 1234", flags, cpu_rdata);
    end
    step();
    @(negedge clk);
    checks++;
    if (flags !== 7'b0110000 || mem_adr !== 16'h0040 || mem_wdata !== 16'h7777) begin
      errors++; $display("FAIL rdr_t3: flags %b adr %h wd %h exp 0110000 0040 7777", flags, mem_adr, mem_wdata);
    end
    step();
    set_ldr(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (flags !== 7'b0000001) begin errors++; $display("FAIL rdr_t4: flags %b exp 0000001", flags); end
    step();
  endtask

  task automatic test_withdrawal();
    set_cpu(1'b1, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    checks++;
    if (flags !== 7'b1000001) begin errors++; $display("FAIL wd_issue: flags %b exp 1000001", flags); end
    step();
    set_cpu(1'b0, 1'b0, '0, '0);
    set_ldr(1'b1, 1'b1, 16'h0050, 16'h9999);
    @(negedge clk);
    checks++;
    if (flags !== 7'b0001000) begin errors++; $display("FAIL wd_t1: flags %b exp 0001000", flags); end
    step();
    set_ldr(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (flags !== 7'b0001100) begin errors++; $display("FAIL wd_t2: flags %b exp 0001100", flags); end
    step();
    @(negedge clk);
    checks++;
    if (flags !== 7'b0000000 || mem_adr !== 16'h0010) begin
      errors++; $display("FAIL wd_t3: flags %b adr %h exp 0000000 0010", flags, mem_adr);
    end
    step();
    checks++;
    if (mem[12'h050] !== 16'h0000) begin errors++; $display("FAIL wd_mem: [50]=%h exp 0000", mem[12'h050]); end
  endtask

  task automatic test_reset_mid_read();
    set_cpu(1'b1, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    checks++;
    if (flags !== 7'b1000000) begin errors++; $display("FAIL rmr_issue: flags %b exp 1000000", flags); end
    step();
    set_cpu(1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (flags !== 7'b0000000 || mem_adr !== 16'h0 || cpu_rdata !== 16'h0) begin
      errors++; $display("FAIL rmr_in_reset: flags %b adr %h crd %h exp 0000000 0000 0000", flags, mem_adr, cpu_rdata);
    end
    step();
    reset = 1'b0;
    set_cpu(1'b1, 1'b1, 16'h0060, 16'h1111);
    set_ldr(1'b1, 1'b1, 16'h0070, 16'h2222);
    @(negedge clk);
    checks++;
    if (flags !== 7'b1010000 || mem_adr !== 16'h0060) begin
      errors++; $display("FAIL rmr_first_tie: flags %b adr %h exp 1010000 0060", flags, mem_adr);
    end
    step();
    set_cpu(1'b0, 1'b0, '0, '0);
    set_ldr(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (flags !== 7'b0000000) begin errors++; $display("FAIL rmr_after: flags %b exp 0000000", flags); end
    step();
  endtask

  initial begin
    reset = 1'b1;
    set_cpu(1'b0, 1'b0, '0, '0);
    set_ldr(1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_read();
    test_contention();
    test_write_read();
    test_req_during_read();
    test_withdrawal();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-port 16-bit program/data memory between two requesters: the CPU (instruction fetch, LD, STO) and the program loader/debug port. It serialises accesses using round-robin arbitration with one outstanding transaction at a time. Read latency is programmable, and per-requester grant and read-valid handshakes are provided. It sits between the CPU execution unit/control unit memory signals and the memory block.

Parameters:
AW, 16, memory address width
DW, 16, memory data width
RD_LAT, 1, memory read latency in cycles (legal 1..3), from the issue edge to mem_rdata valid

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request; held until cpu_gnt
cpu_we  in  1  1 = write, 0 = read
cpu_adr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_gnt  out  1  one-cycle pulse in the CPU issue cycle
cpu_rvalid  out  1  one-cycle pulse when cpu_rdata is valid
cpu_rdata  out  DW  read data; 0 when cpu_rvalid is low
ldr_req, ldr_we, ldr_adr, ldr_wdata, ldr_gnt, ldr_rvalid, ldr_rdata  same as the cpu_* ports, for the loader
mem_adr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_we  out  1  memory write enable
mem_rdata  in  DW  memory read data
busy  out  1  high while a read is outstanding
owner  out  1  current/last owner (0 = CPU, 1 = loader)

Behaviour:
- Reset: clk and reset only; reset is synchronous and active-high.
  - While reset is high, every output is forced to 0, state goes to IDLE, the latency counter clears and last_owner becomes LDR (so the CPU wins the first tie).
- States: IDLE and RD_WAIT.
- IDLE, no request: outputs stay 0 and mem_adr holds its last value.
- IDLE, at least one request: the winner is chosen combinationally in the same cycle (issue cycle).
  - Only one request: that requester wins.
  - Both requesting: the requester that is not last_owner wins.
- Issue cycle:
  - Winner's gnt = 1.
  - mem_adr and mem_wdata are driven from the winner.
  - mem_we = winner's we.
  - last_owner and owner update to the winner on the clock edge.
- Write issue: completes at that edge; state stays IDLE.
  - Back-to-back writes are possible every cycle; under contention they alternate.
- Read issue: the issued address is latched, the counter loads RD_LAT, and the next state is RD_WAIT.
- RD_WAIT:
  - mem_adr is held at the latched address; mem_we = 0; busy = 1; no gnt is issued.
  - The counter decrements each cycle.
  - The counter reaches valid (RD_LAT cycles after the issue edge) in the cycle where owner's rvalid = 1 and owner's rdata = mem_rdata. Next state is IDLE.
- Read occupancy is RD_LAT+1 cycles; the next issue is no earlier than the cycle after rvalid.
- Requesters hold req/we/adr/wdata stable until gnt.
  - Dropping req before gnt is legal and produces no access.
  - A req held high after gnt is treated as a new request.
- Non-owner rvalid and rdata are always 0.
- Reset asserted mid-read: the transaction is discarded, no rvalid is produced, and arbitration restarts as after power-up.
- RD_LAT outside 1..3 is a configuration error; a simulation-only assertion flags it.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding (IDLE, RD_WAIT)
  - owner constants OWN_CPU = 1'b0, OWN_LDR = 1'b1
  - the counter width derived from the maximum RD_LAT
- One sub-module, rr_arb2: a 2-requester round-robin picker.
  - Inputs: req[1:0], last_owner.
  - Outputs: one-hot grant and winner index.
  - Purely combinational.
- The top level holds the FSM, latency counter, address latch and data steering.

Test Plan:
- Single read: RD_LAT=2; memory preloaded with 0x1234 at 0x0010; cpu_req read at 0x0010 → cpu_gnt at T0, busy at T1–T2, cpu_rvalid with 0x1234 at T2, ldr_rvalid=0 throughout.
- Contention after reset: cpu_req and ldr_req both asserted continuously as writes → grants go CPU, LDR, CPU, LDR on consecutive cycles, and mem_we is high every cycle.
- Write-then-read coherence: loader writes 0xBEEF to 0x0100, then the CPU reads 0x0100 → cpu_rdata = 0xBEEF with cpu_rvalid, RD_LAT cycles after cpu_gnt.
- Request during read: ldr_req asserted while a CPU read is in RD_WAIT → no ldr_gnt until the cycle after cpu_rvalid, then ldr_gnt=1.
- Reset mid-read: reset asserted in the cycle after a CPU read issue → no cpu_rvalid ever appears, all outputs are 0 during reset, and the first post-reset tie grants the CPU.
- Request withdrawal: ldr_req pulsed for one cycle while a read is outstanding and dropped before grant → mem_we never asserts for it and no ldr_gnt is produced.
